// File: rtl/snek_step_if.sv
// Move request handshake between the step scheduler and the snake datapath.
// The master raises step_req with step_dir held stable until the slave returns step_ack.
interface snek_step_if;
  logic       step_req;
  logic [1:0] step_dir;
  logic       step_ack;

  modport master (output step_req, output step_dir, input step_ack);
  modport slave  (input step_req, input step_dir, output step_ack);
endinterface

// File: rtl/snek_step_sched.sv
// Snek move scheduler: filters button turns into a small queue and issues one
// move request every frames_per_step frames over a req/ack handshake.
//
// state   | meaning
// S_RUN   | idle between moves; a due frame tick launches the next move
// S_ISSUE | move request outstanding, waiting for step_ack
module snek_step_sched #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TICK_W     = 6,
  parameter logic [1:0] INIT_DIR   = 2'd3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  buttons,
  input  logic                        frame_tick,
  input  logic [TICK_W-1:0]           frames_per_step,
  input  logic                        pause,
  snek_step_if.master                 step_bus,
  output logic [1:0]                  cur_dir,
  output logic [$clog2(FIFO_DEPTH):0] q_count,
  output logic                        drop,
  output logic                        overrun
);

  localparam int QW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]        state;
  logic [1:0]        fifo_mem [FIFO_DEPTH];
  logic [QW-1:0]     wr_ptr;
  logic [QW-1:0]     rd_ptr;
  logic [QW:0]       count;
  logic [TICK_W-1:0] frame_cnt;
  logic [TICK_W-1:0] frame_last;
  logic [1:0]        last_dir;
  logic [1:0]        cur_dir_q;
  logic [1:0]        step_dir_q;
  logic              step_req_q;
  logic              drop_q;
  logic              overrun_q;

  logic       sel_valid;
  logic [1:0] cand_dir;
  logic       tick_live;
  logic       due;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       is_dup;
  logic       is_rev;
  logic       blocked;
  logic [1:0] next_dir;

  // Priority up > down > left > right; lower-priority bits are discarded silently.
  always_comb begin
    sel_valid = 1'b1;
    cand_dir  = 2'd0;
    if (buttons[3])      cand_dir = 2'd0;
    else if (buttons[2]) cand_dir = 2'd1;
    else if (buttons[1]) cand_dir = 2'd2;
    else if (buttons[0]) cand_dir = 2'd3;
    else                 sel_valid = 1'b0;
  end

  assign frame_last = (frames_per_step == '0) ? '0 : frames_per_step - 1'b1;
  assign tick_live  = frame_tick & ~pause;
  assign due        = tick_live && (frame_cnt == frame_last);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (QW+1)'(FIFO_DEPTH));
  // Pop only sees the pre-push state, so a same-cycle push into an empty queue waits.
  assign pop        = (state == S_RUN) && due && !fifo_empty;

  assign is_dup  = (cand_dir == last_dir);
  assign is_rev  = (cand_dir[1] == last_dir[1]) && (cand_dir[0] != last_dir[0]);
  assign blocked = fifo_full && !pop;
  assign push    = sel_valid && !is_dup && !is_rev && !blocked;

  assign next_dir = pop ? fifo_mem[rd_ptr] : cur_dir_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cand_dir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_cnt  <= '0;
      last_dir   <= INIT_DIR;
      cur_dir_q  <= INIT_DIR;
      step_dir_q <= INIT_DIR;
      step_req_q <= 1'b0;
      drop_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      drop_q    <= sel_valid & ~push;
      overrun_q <= 1'b0;

      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_dir <= cand_dir;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (tick_live) frame_cnt <= due ? '0 : frame_cnt + 1'b1;

      case (state)
        S_RUN: begin
          if (due) begin
            cur_dir_q  <= next_dir;
            step_dir_q <= next_dir;
            step_req_q <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        default: begin
          // A move falling due while the previous one is unacknowledged is lost.
          if (due) overrun_q <= 1'b1;
          if (step_bus.step_ack) begin
            step_req_q <= 1'b0;
            state      <= S_RUN;
          end
        end
      endcase
    end
  end

  assign step_bus.step_req = step_req_q;
  assign step_bus.step_dir = step_dir_q;
  assign cur_dir           = cur_dir_q;
  assign q_count           = count;
  assign drop              = drop_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_snek_step_sched.sv
// Scenario bench for snek_step_sched: expected move directions are queued when
// turns are accepted (or a reuse is expected) and popped as requests appear.
module tb_snek_step_sched;
  localparam int TICK_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        buttons;
  logic              frame_tick;
  logic [TICK_W-1:0] frames_per_step;
  logic              pause;
  logic [1:0]        cur_dir;
  logic [2:0]        q_count;
  logic              drop;
  logic              overrun;

  snek_step_if sb_if ();

  snek_step_sched #(.FIFO_DEPTH(4), .TICK_W(TICK_W), .INIT_DIR(2'd3)) dut (
    .clk             (clk),
    .rst             (rst),
    .buttons         (buttons),
    .frame_tick      (frame_tick),
    .frames_per_step (frames_per_step),
    .pause           (pause),
    .step_bus        (sb_if),
    .cur_dir         (cur_dir),
    .q_count         (q_count),
    .drop            (drop),
    .overrun         (overrun)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] d;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    buttons = b;
    cyc();
    buttons = 4'b0;
  endtask

  task automatic ack();
    sb_if.step_ack = 1'b1;
    cyc();
    sb_if.step_ack = 1'b0;
  endtask

  task automatic sb_pop(output logic [1:0] v);
    if (exp_q.size() == 0) v = 2'bxx;
    else v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; buttons = 4'b0; frame_tick = 1'b0; pause = 1'b0;
    frames_per_step = 6'd3; sb_if.step_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    total++; if (sb_if.step_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", sb_if.step_req); end
    total++; if (sb_if.step_dir !== 2'd3) begin bad++; $display("FAIL rst_dir got=%0d want=3", sb_if.step_dir); end
    total++; if (cur_dir !== 2'd3) begin bad++; $display("FAIL rst_cur got=%0d want=3", cur_dir); end
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL rst_q got=%0d want=0", q_count); end
    total++; if ({drop, overrun} !== 2'b00) begin bad++; $display("FAIL rst_pulses got=%b want=00", {drop, overrun}); end
  endtask

  task automatic test_default_moves();
    logic want;
    for (int i = 1; i <= 9; i++) begin
      want = (i % 3 == 0);
      if (want) exp_q.push_back(2'd3);
      tick();
      total++; if (sb_if.step_req !== want) begin bad++; $display("FAIL def_req tick=%0d got=%0b want=%0b", i, sb_if.step_req, want); end
      if (want) begin
        sb_pop(d);
        total++; if (sb_if.step_dir !== d) begin bad++; $display("FAIL def_dir tick=%0d got=%0d want=%0d", i, sb_if.step_dir, d); end
        ack();
        total++; if (sb_if.step_req !== 1'b0) begin bad++; $display("FAIL def_ack tick=%0d got=%0b want=0", i, sb_if.step_req); end
      end
      cyc();
    end
    total++; if (cur_dir !== 2'd3) begin bad++; $display("FAIL def_cur got=%0d want=3", cur_dir); end
  endtask

  task automatic test_turns();
    press(4'b1000); exp_q.push_back(2'd0);
    press(4'b0010); exp_q.push_back(2'd2);
    total++; if (q_count !== 3'd2) begin bad++; $display("FAIL turn_q got=%0d want=2", q_count); end
    for (int m = 0; m < 2; m++) begin
      tick(); tick(); tick();
      sb_pop(d);
      total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL turn_mv m=%0d req=%0b dir=%0d want_dir=%0d", m, sb_if.step_req, sb_if.step_dir, d); end
      ack();
    end
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL turn_q_end got=%0d want=0", q_count); end
  endtask

  task automatic test_drops();
    // Steer last_dir back to right via up then right, then drain.
    press(4'b1000); exp_q.push_back(2'd0);
    press(4'b0001); exp_q.push_back(2'd3);
    for (int m = 0; m < 2; m++) begin
      tick(); tick(); tick();
      sb_pop(d);
      total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL drp_mv m=%0d req=%0b dir=%0d want_dir=%0d", m, sb_if.step_req, sb_if.step_dir, d); end
      ack();
    end
    press(4'b0010);
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL drp_rev got=%0b want=1", drop); end
    cyc();
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL drp_one got=%0b want=0", drop); end
    press(4'b0001);
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL drp_dup got=%0b want=1", drop); end
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL drp_q got=%0d want=0", q_count); end
  endtask

  task automatic test_priority();
    press(4'b1001); exp_q.push_back(2'd0);
    total++; if (q_count !== 3'd1 || drop !== 1'b0) begin bad++; $display("FAIL pri got q=%0d drop=%0b want q=1 drop=0", q_count, drop); end
    tick(); tick(); tick();
    sb_pop(d);
    total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL pri_mv req=%0b dir=%0d want_dir=%0d", sb_if.step_req, sb_if.step_dir, d); end
    ack();
  endtask

  task automatic test_fifo_full();
    logic [3:0] seq [5];
    seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b0010; seq[3] = 4'b1000; seq[4] = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      press(seq[k]);
      if (k < 4) exp_q.push_back(seq[k][3] ? 2'd0 : 2'd2);
      total++; if (drop !== (k == 4)) begin bad++; $display("FAIL full_drop k=%0d got=%0b", k, drop); end
    end
    total++; if (q_count !== 3'd4) begin bad++; $display("FAIL full_q got=%0d want=4", q_count); end
    // Push into a full queue is allowed when a pop happens in the same cycle.
    tick(); tick();
    buttons = 4'b0010; exp_q.push_back(2'd2);
    tick();
    buttons = 4'b0;
    sb_pop(d);
    total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL full_pp req=%0b dir=%0d want_dir=%0d", sb_if.step_req, sb_if.step_dir, d); end
    total++; if (q_count !== 3'd4 || drop !== 1'b0) begin bad++; $display("FAIL full_pp_q q=%0d drop=%0b want q=4 drop=0", q_count, drop); end
    ack();
  endtask

  task automatic test_overrun();
    tick(); tick(); tick();
    sb_pop(d);
    total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL ovr_mv req=%0b dir=%0d want_dir=%0d", sb_if.step_req, sb_if.step_dir, d); end
    tick(); tick();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%0b want=0", overrun); end
    tick();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%0b want=1", overrun); end
    total++; if (q_count !== 3'd3 || sb_if.step_dir !== d || sb_if.step_req !== 1'b1) begin bad++; $display("FAIL ovr_hold q=%0d dir=%0d req=%0b want q=3 dir=%0d req=1", q_count, sb_if.step_dir, sb_if.step_req, d); end
    cyc();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one got=%0b want=0", overrun); end
    ack();
    total++; if (sb_if.step_req !== 1'b0) begin bad++; $display("FAIL ovr_ack got=%0b want=0", sb_if.step_req); end
  endtask

  task automatic test_pause();
    frames_per_step = 6'd2;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (sb_if.step_req !== 1'b0) begin bad++; $display("FAIL pau_req i=%0d got=%0b want=0", i, sb_if.step_req); end
    end
    pause = 1'b0;
    tick();
    total++; if (sb_if.step_req !== 1'b0) begin bad++; $display("FAIL pau_rel1 got=%0b want=0", sb_if.step_req); end
    tick();
    sb_pop(d);
    total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL pau_mv req=%0b dir=%0d want_dir=%0d", sb_if.step_req, sb_if.step_dir, d); end
    ack();
    // Counter held at 1 across the pause: one tick after release is due.
    tick();
    pause = 1'b1;
    press(4'b1000); exp_q.push_back(2'd0);
    total++; if (q_count !== 3'd3) begin bad++; $display("FAIL pau_press got=%0d want=3", q_count); end
    tick(); tick(); tick();
    total++; if (sb_if.step_req !== 1'b0) begin bad++; $display("FAIL pau_req2 got=%0b want=0", sb_if.step_req); end
    pause = 1'b0;
    tick();
    sb_pop(d);
    total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL pau_held req=%0b dir=%0d want_dir=%0d", sb_if.step_req, sb_if.step_dir, d); end
    ack();
  endtask

  task automatic test_fps_zero();
    frames_per_step = 6'd0;
    exp_q.push_back(2'd0);
    for (int m = 0; m < 3; m++) begin
      tick();
      sb_pop(d);
      total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== d) begin bad++; $display("FAIL fz_mv m=%0d req=%0b dir=%0d want_dir=%0d", m, sb_if.step_req, sb_if.step_dir, d); end
      ack();
    end
    total++; if (q_count !== 3'd0 || cur_dir !== 2'd0) begin bad++; $display("FAIL fz_end q=%0d cur=%0d want q=0 cur=0", q_count, cur_dir); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    tick();
    total++; if (sb_if.step_req !== 1'b1 || sb_if.step_dir !== 2'd0) begin bad++; $display("FAIL rm_req req=%0b dir=%0d want 1/0", sb_if.step_req, sb_if.step_dir); end
    press(4'b0010);
    total++; if (q_count !== 3'd1) begin bad++; $display("FAIL rm_q got=%0d want=1", q_count); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    total++; if (sb_if.step_req !== 1'b0 || q_count !== 3'd0 || cur_dir !== 2'd3) begin bad++; $display("FAIL rm_state req=%0b q=%0d cur=%0d want 0/0/3", sb_if.step_req, q_count, cur_dir); end
  endtask

  initial begin
    test_reset();
    test_default_moves();
    test_turns();
    test_drops();
    test_priority();
    test_fifo_full();
    test_overrun();
    test_pause();
    test_fps_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
